// File: rtl/snake_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_timing_pkg
// Description : Shared timing constants and types for the snake game-step
//               divider (50 MHz board defaults, level width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package snake_timing_pkg;

   // Board defaults: 50 MHz clock, ~2 Hz game step at level 0
   localparam int DEF_CNT_W      = 24;
   localparam int DEF_BASE_HALF  = 12500000;
   localparam int DEF_STEP       = 1250000;
   localparam int DEF_NUM_LEVELS = 8;
   localparam int DEF_CLEAR_LEN  = 1;

   // Width of the level field for the default level count
   localparam int LEVEL_W = $clog2(DEF_NUM_LEVELS);

   // Decoded speed request for one clock; reset has priority over up
   typedef enum logic [1:0] {
      REQ_NONE  = 2'd0,
      REQ_UP    = 2'd1,
      REQ_RESET = 2'd2
   } speed_req_e;

   // Level field width for an arbitrary level count (never zero)
   function automatic int level_width(input int num_levels);
      return (num_levels > 1) ? $clog2(num_levels) : 1;
   endfunction

endpackage : snake_timing_pkg
`default_nettype wire

// File: rtl/game_tick_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_divider_if
// Description : Control/status bundle between the game logic and the
//               game-step divider. master = game logic, slave = divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_tick_divider_if
   import snake_timing_pkg::*;
#(
   parameter int LEVEL_W = snake_timing_pkg::LEVEL_W
);

   logic               enable;
   logic               speed_up;
   logic               speed_reset;
   logic               rclock;
   logic               tick;
   logic               clear;
   logic [LEVEL_W-1:0] level;

   modport master (
      output enable,
      output speed_up,
      output speed_reset,
      input  rclock,
      input  tick,
      input  clear,
      input  level
   );

   modport slave (
      input  enable,
      input  speed_up,
      input  speed_reset,
      output rclock,
      output tick,
      output clear,
      output level
   );

endinterface : game_tick_divider_if
`default_nettype wire

// File: rtl/tick_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tick_level_ctrl
// Description : Speed-level bookkeeping for the game-step divider. Holds the
//               pending (requested) level and the applied level, and derives
//               the half-period terminal count from the applied level.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_level_ctrl
   import snake_timing_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int BASE_HALF  = DEF_BASE_HALF,
   parameter int STEP       = DEF_STEP,
   parameter int NUM_LEVELS = DEF_NUM_LEVELS,
   parameter int LEVEL_W    = level_width(DEF_NUM_LEVELS)
)(
   input  wire logic               clock,
   input  wire logic               resetn,
   input  wire logic               speed_up,
   input  wire logic               speed_reset,
   input  wire logic               apply,
   output logic      [LEVEL_W-1:0] level,
   output logic      [CNT_W-1:0]   half_term
);

   localparam logic [LEVEL_W-1:0] c_max_level = LEVEL_W'(NUM_LEVELS - 1);
   localparam logic [CNT_W-1:0]   c_base_half = CNT_W'(BASE_HALF);
   localparam logic [CNT_W-1:0]   c_step      = CNT_W'(STEP);

   speed_req_e         w_req;
   logic [LEVEL_W-1:0] r_pending;
   logic [LEVEL_W-1:0] r_level;

   // Collapse the two request lines into one request; reset wins a tie
   always_comb begin
      w_req = REQ_NONE;
      if (speed_reset)
         w_req = REQ_RESET;
      else if (speed_up)
         w_req = REQ_UP;
   end

   // Pending level follows requests every cycle, saturating at the top level
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_pending <= '0;
      end else begin
         case (w_req)
            REQ_RESET: r_pending <= '0;
            REQ_UP:    if (r_pending != c_max_level)
                          r_pending <= r_pending + LEVEL_W'(1);
            default:   r_pending <= r_pending;
         endcase
      end
   end

   // Applied level only changes at the falling phase boundary
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         r_level <= '0;
      else if (apply)
         r_level <= r_pending;
   end

   // Parameter constraints guarantee this never wraps
   assign half_term = c_base_half - (CNT_W'(r_level) * c_step);
   assign level     = r_level;

endmodule : tick_level_ctrl
`default_nettype wire

// File: rtl/game_tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_divider
// Description : Game-step clock generator. Divides the board clock into the
//               rclock square wave with a one-cycle tick on each rising
//               phase and a clear pulse at the start of each low phase.
//               Speed levels shorten the half period; changes take effect
//               only at the falling boundary. enable=0 freezes the timing.
// Revision    : 1.0 - initial release
// ============================================================================
module game_tick_divider
   import snake_timing_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int BASE_HALF  = DEF_BASE_HALF,
   parameter int STEP       = DEF_STEP,
   parameter int NUM_LEVELS = DEF_NUM_LEVELS,
   parameter int CLEAR_LEN  = DEF_CLEAR_LEN
)(
   input  wire logic          clock,
   input  wire logic          resetn,
   game_tick_divider_if.slave bus
);

   localparam int LEVEL_W = level_width(NUM_LEVELS);

   localparam logic [CNT_W-1:0] c_clear_len = CNT_W'(CLEAR_LEN);

   // Reject parameter sets that would underflow the terminal count or
   // leave no room for the clear window inside the shortest low phase
   if (CLEAR_LEN < 1) begin : g_chk_clear_len
      $error("game_tick_divider: CLEAR_LEN must be >= 1");
   end
   if (NUM_LEVELS < 2) begin : g_chk_levels
      $error("game_tick_divider: NUM_LEVELS must be >= 2");
   end
   if (longint'(BASE_HALF) - longint'(NUM_LEVELS - 1) * longint'(STEP)
       < longint'(CLEAR_LEN + 1)) begin : g_chk_min_half
      $error("game_tick_divider: fastest half period too short");
   end
   if (longint'(BASE_HALF) >= (longint'(1) << CNT_W)) begin : g_chk_cnt_w
      $error("game_tick_divider: BASE_HALF does not fit in CNT_W bits");
   end

   logic [CNT_W-1:0]   r_count;
   logic               r_rclock;
   logic               r_tick;
   logic               r_clear;
   logic [CNT_W-1:0]   w_half_term;
   logic [LEVEL_W-1:0] w_level;
   logic               w_at_term;
   logic               w_rise;
   logic               w_fall;

   assign w_at_term = (r_count == w_half_term);
   assign w_rise    = bus.enable & w_at_term & ~r_rclock;
   assign w_fall    = bus.enable & w_at_term &  r_rclock;

   tick_level_ctrl #(
      .CNT_W      (CNT_W),
      .BASE_HALF  (BASE_HALF),
      .STEP       (STEP),
      .NUM_LEVELS (NUM_LEVELS),
      .LEVEL_W    (LEVEL_W)
   ) u_level_ctrl (
      .clock       (clock),
      .resetn      (resetn),
      .speed_up    (bus.speed_up),
      .speed_reset (bus.speed_reset),
      .apply       (w_fall),
      .level       (w_level),
      .half_term   (w_half_term)
   );

   // Half-period counter and game-step square wave; both freeze while paused
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_count  <= '0;
         r_rclock <= 1'b0;
      end else if (bus.enable) begin
         if (w_at_term) begin
            r_count  <= '0;
            r_rclock <= ~r_rclock;
         end else begin
            r_count  <= r_count + CNT_W'(1);
         end
      end
   end

   // Tick rises with rclock; clear covers the first CLEAR_LEN low-phase counts
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_tick  <= 1'b0;
         r_clear <= 1'b0;
      end else begin
         r_tick  <= w_rise;
         r_clear <= bus.enable & ~r_rclock & (r_count < c_clear_len);
      end
   end

   assign bus.rclock = r_rclock;
   assign bus.tick   = r_tick;
   assign bus.clear  = r_clear;
   assign bus.level  = w_level;

endmodule : game_tick_divider
`default_nettype wire

// File: doc/game_tick_divider.md
Name: game_tick_divider

Overview:
- Parametrised successor to the game refresh divider. Produces the snake game-step clock (`rclock`), a single-cycle `tick` strobe on each game step, and a multi-cycle `clear` pulse at the start of each low phase.
- Adds run-time speed levels, with changes applied only at period boundaries, plus a pause/enable input.
- Sits between the board clock and the snake state/render logic.

Parameters:
- CNT_W, 24, counter width in bits.
- BASE_HALF, 12500000, half-period terminal count at level 0. One half phase lasts BASE_HALF+1 clocks.
- STEP, 1250000, terminal-count reduction per speed level.
- NUM_LEVELS, 8, number of speed levels (0..NUM_LEVELS-1).
- CLEAR_LEN, 1, width of the `clear` pulse in clocks. Must satisfy CLEAR_LEN >= 1.
- Constraint: BASE_HALF - (NUM_LEVELS-1)*STEP >= CLEAR_LEN+1, and BASE_HALF < 2^CNT_W. Violations are an elaboration error.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  1 = run; 0 = pause (counter and phase frozen).
- speed_up  in  1  single-cycle request: raise level by one.
- speed_reset  in  1  single-cycle request: return to level 0.
- rclock  out  1  game-step square wave.
- tick  out  1  one-cycle strobe, high in the first cycle that rclock reads 1.
- clear  out  1  high for CLEAR_LEN cycles at the start of each low phase.
- level  out  $clog2(NUM_LEVELS)  speed level currently in effect.

Behaviour:
- Reset (asynchronous assert): counter=0, rclock=0, tick=0, clear=0, level=0, pending level=0. Deassertion is synchronised to clock by the system reset bridge.
- half_term = BASE_HALF - level*STEP, computed in CNT_W bits from the applied level only. The subtraction never underflows, by the parameter constraint.
- Counter, enable=1:
  - If counter==half_term: counter<=0 and rclock<=~rclock.
  - Otherwise counter<=counter+1.
- tick is registered: tick<=1 exactly in the cycle where rclock toggles 0->1, so tick and rclock rise together. Otherwise tick<=0.
- clear is registered: clear<=1 when rclock==0 and counter<CLEAR_LEN; otherwise 0.
  - After reset, clear is high for cycles 1..CLEAR_LEN following release.
  - After each falling toggle, clear is high for CLEAR_LEN cycles starting the cycle after the toggle.
- Speed requests:
  - The pending level updates on any cycle.
  - speed_up increments pending, saturating at NUM_LEVELS-1.
  - speed_reset forces pending to 0.
  - If both are asserted in the same cycle, speed_reset wins.
  - Requests are honoured while enable=0.
- Level apply: level<=pending only on the 1->0 toggle of rclock, so every half phase runs with one consistent half_term. The new level governs the next low phase.
- Pause (enable=0): counter, rclock and level hold; tick<=0, clear<=0. On resume, counting continues from the held value. An interrupted clear window does not re-emit cycles already consumed.
- Reset mid-period aborts immediately. No tick is emitted for a partial period.
- No combinational path from inputs to outputs.

Decomposition:
- Package `snake_timing_pkg`:
  - Default BASE_HALF/STEP/NUM_LEVELS constants for the 50 MHz board.
  - LEVEL_W = $clog2(NUM_LEVELS) localparam helper.
- Sub-module `tick_level_ctrl`:
  - Contains the pending and applied level registers, the saturation logic and the half_term computation.
  - Inputs: speed_up, speed_reset, apply strobe.
  - Outputs: level, half_term.
- Top level keeps the counter, rclock, tick and clear.

Test Plan:
Bench parameters: BASE_HALF=10, STEP=3, NUM_LEVELS=3, CLEAR_LEN=2, enable=1, reset released at cycle 0.
- Free run at level 0 → clear high cycles 1-2.
  - rclock rises at cycle 11, with tick high that cycle only.
  - rclock falls at cycle 22; clear high at cycles 23-24.
  - Period is 22 clocks.
- speed_up pulsed at cycle 5 → level stays 0 until cycle 22, then becomes 1. The next half phases are 8 clocks: rclock rises at cycle 30, falls at 38.
- Three speed_up pulses, then wait one falling edge → level saturates at 2; half phase is 5 clocks.
- speed_up and speed_reset in the same cycle at level 2 → after the next fall, level=0 and half phase returns to 11 clocks.
- enable=0 at cycles 6-15 → counter and rclock frozen, tick and clear low. rclock rises at cycle 21, not 11.
- resetn asserted at cycle 15 (rclock=1) → all outputs 0 immediately. After release, clear is high for the 2 cycles after release, and the next tick comes 11 cycles after release.
